cpu_core: RTL and testbench

//  8-bit single-cycle CPU with internal program ROM, 8x8 register file and 64-byte data RAM.
//  Top of the processor; exposes PC, halt and all registers for bench observation.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/cpu_alu.sv | 36 +++
 rtl/cpu_core.sv | 146 ++++++++++++++
 tb/tb_cpu_core.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit single-cycle CPU: opcodes, ALU operation codes and flags.
// Optional shifter is controlled by the CPU_SHIFT_EN macro (see cpu_alu / cpu_core).
package cpu_pkg;

    localparam logic [3:0] OP_LOADI = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_STORE = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_MOV   = 4'hA;
    localparam logic [3:0] OP_CMP   = 4'hB;
    localparam logic [3:0] OP_JUMP  = 4'hC;
    localparam logic [3:0] OP_JZ    = 4'hD;
    localparam logic [3:0] OP_JNZ   = 4'hE;
    localparam logic [3:0] OP_F     = 4'hF;

    localparam logic [15:0] HALT_WORD = 16'hF000;

    localparam int unsigned ALU_OP_W = 4;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SHL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SHR  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_NOT  = 4'd8;

    localparam int unsigned FLAG_W = 3;
    typedef struct packed {
        logic z;
        logic n;
        logic c;
    } flags_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU; c is carry-out for ADD and borrow for SUB.
// Shift operations exist only when CPU_SHIFT_EN is defined.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [7:0]          a,
    input  logic [7:0]          b,
    output logic [7:0]          result,
    output logic                z,
    output logic                n,
    output logic                c
);

    always_comb begin
        result = a;
        c      = 1'b0;
        case (alu_op)
            ALU_ADD: {c, result} = {1'b0, a} + {1'b0, b};
            ALU_SUB: {c, result} = {1'b0, a} - {1'b0, b};
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
`ifdef CPU_SHIFT_EN
            ALU_SHL: result = a << b[2:0];
            ALU_SHR: result = a >> b[2:0];
`endif
            ALU_NOT: result = ~a;
            default: result = a;
        endcase
    end

    assign z = (result == 8'd0);
    assign n = result[7];

endmodule

// File: rtl/cpu_core.sv
// 8-bit single-cycle CPU: ROM fetch, decode, register file, data RAM and sticky halt.
// Define CPU_SHIFT_EN to enable SHL/SHR; otherwise opcodes 8/9 act as NOPs.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    output logic       halt,
    output logic [7:0] pc_out,
    output logic [7:0] reg0_out,
    output logic [7:0] reg1_out,
    output logic [7:0] reg2_out,
    output logic [7:0] reg3_out,
    output logic [7:0] reg4_out,
    output logic [7:0] reg5_out,
    output logic [7:0] reg6_out,
    output logic [7:0] reg7_out
);

    logic [7:0]  pc;
    logic [7:0]  regs [8];
    logic [7:0]  dmem [DMEM_DEPTH];
    flags_t      flags;
    logic [15:0] instruction;

    logic [3:0]          op;
    logic [2:0]          fa, fb;
    logic [5:0]          imm6;
    logic [7:0]          ra, rb;
    logic                is_halt;
    logic [7:0]          pc_next;
    logic                wr_en, mem_we, flags_we;
    logic [2:0]          wr_addr;
    logic [7:0]          wr_data;
    logic [ALU_OP_W-1:0] alu_op;
    logic [7:0]          alu_result;
    logic                alu_z, alu_n, alu_c;

    // Program ROM; words beyond the program decode as HALT.
    always_comb begin
        instruction = HALT_WORD;
        if (int'(pc) < IMEM_DEPTH) begin
            case (pc)
                8'd0:    instruction = 16'h000F;
                8'd1:    instruction = 16'h0205;
                8'd2:    instruction = 16'h2040;
                8'd3:    instruction = 16'h043F;
                8'd4:    instruction = 16'h3280;
                8'd5:    instruction = 16'hA4C0;
                8'd6:    instruction = 16'h0832;
                8'd7:    instruction = 16'h6632;
                8'd8:    instruction = 16'h7A32;
                8'd9:    instruction = 16'hAB80;
                8'd10:   instruction = 16'h0E2A;
                default: instruction = HALT_WORD;
            endcase
        end
    end

    assign op      = instruction[15:12];
    assign fa      = instruction[11:9];
    assign fb      = instruction[8:6];
    assign imm6    = instruction[5:0];
    assign ra      = regs[fa];
    assign rb      = regs[fb];
    assign is_halt = (op == OP_F) && (instruction[11:0] == 12'd0);

    cpu_alu u_alu (
        .alu_op (alu_op),
        .a      (ra),
        .b      (rb),
        .result (alu_result),
        .z      (alu_z),
        .n      (alu_n),
        .c      (alu_c)
    );

    always_comb begin
        pc_next  = pc + 8'd1;
        wr_en    = 1'b0;
        wr_addr  = fb;
        wr_data  = alu_result;
        mem_we   = 1'b0;
        flags_we = 1'b0;
        alu_op   = ALU_PASS;
        case (op)
            OP_LOADI: begin wr_en = 1'b1; wr_addr = fa; wr_data = {2'b00, imm6}; end
            OP_ADD:   begin alu_op = ALU_ADD; wr_en = 1'b1; flags_we = 1'b1; end
            OP_SUB:   begin alu_op = ALU_SUB; wr_en = 1'b1; flags_we = 1'b1; end
            OP_AND:   begin alu_op = ALU_AND; wr_en = 1'b1; end
            OP_OR:    begin alu_op = ALU_OR;  wr_en = 1'b1; end
            OP_XOR:   begin alu_op = ALU_XOR; wr_en = 1'b1; end
            OP_STORE: mem_we = 1'b1;
            OP_LOAD:  begin wr_en = 1'b1; wr_addr = fa; wr_data = dmem[imm6]; end
`ifdef CPU_SHIFT_EN
            OP_SHL:   begin alu_op = ALU_SHL; wr_en = 1'b1; end
            OP_SHR:   begin alu_op = ALU_SHR; wr_en = 1'b1; end
`else
            OP_SHL, OP_SHR: ;
`endif
            OP_MOV:   begin alu_op = ALU_PASS; wr_en = 1'b1; end
            OP_CMP:   begin alu_op = ALU_SUB; flags_we = 1'b1; end
            OP_JUMP:  pc_next = {2'b00, imm6};
            OP_JZ:    if (ra == 8'd0) pc_next = {2'b00, imm6};
            OP_JNZ:   if (ra != 8'd0) pc_next = {2'b00, imm6};
            default: begin
                if (is_halt) begin
                    pc_next = pc;
                end else begin
                    alu_op = ALU_NOT;
                    wr_en  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= 8'd0;
            halt  <= 1'b0;
            flags <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
            for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] <= 8'd0;
        end else if (!halt) begin
            pc <= pc_next;
            if (wr_en)    regs[wr_addr] <= wr_data;
            if (mem_we)   dmem[imm6]    <= ra;
            if (flags_we) flags         <= '{z: alu_z, n: alu_n, c: alu_c};
            if (is_halt)  halt          <= 1'b1;
        end
    end

    assign pc_out   = pc;
    assign reg0_out = regs[0];
    assign reg1_out = regs[1];
    assign reg2_out = regs[2];
    assign reg3_out = regs[3];
    assign reg4_out = regs[4];
    assign reg5_out = regs[5];
    assign reg6_out = regs[6];
    assign reg7_out = regs[7];

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: ROM program table, halt hold, mid-run reset and ROM overrides.
// Shift expectations follow the CPU_SHIFT_EN macro.
module tb_cpu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       halt;
    logic [7:0] pc_out;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7;

    int total = 0;
    int bad   = 0;

    logic        ovr_en = 1'b0;
    logic [15:0] ovr [16];
    logic [15:0] ovr_word;

    cpu_core dut (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .pc_out   (pc_out),
        .reg0_out (r0),
        .reg1_out (r1),
        .reg2_out (r2),
        .reg3_out (r3),
        .reg4_out (r4),
        .reg5_out (r5),
        .reg6_out (r6),
        .reg7_out (r7)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] exp_pc;
        int         ridx;
        logic [7:0] exp_val;
        logic       exp_halt;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [7:0] get_reg(input int idx);
        case (idx)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            4: return r4;
            5: return r5;
            6: return r6;
            default: return r7;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_ovr();
        if (ovr_en) begin
            ovr_word = ovr[pc_out[3:0]];
            force dut.instruction = ovr_word;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_ovr();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        apply_ovr();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_final(input string tag);
        check({tag, " halt"}, {15'd0, halt}, 16'd1);
        check({tag, " pc"}, {8'd0, pc_out}, 16'd11);
        check({tag, " r0"}, {8'd0, r0}, 16'd15);
        check({tag, " r1"}, {8'd0, r1}, 16'd10);
        check({tag, " r2"}, {8'd0, r2}, 16'd10);
        check({tag, " r3"}, {8'd0, r3}, 16'd10);
        check({tag, " r4"}, {8'd0, r4}, 16'd50);
        check({tag, " r5"}, {8'd0, r5}, 16'd10);
        check({tag, " r6"}, {8'd0, r6}, 16'd10);
        check({tag, " r7"}, {8'd0, r7}, 16'd42);
    endtask

    initial begin
        logic [7:0] sh1, sh2;

        vecs[0]  = '{8'd1,  0, 8'd15, 1'b0};
        vecs[1]  = '{8'd2,  1, 8'd5,  1'b0};
        vecs[2]  = '{8'd3,  1, 8'd10, 1'b0};
        vecs[3]  = '{8'd4,  2, 8'd63, 1'b0};
        vecs[4]  = '{8'd5,  2, 8'd10, 1'b0};
        vecs[5]  = '{8'd6,  3, 8'd10, 1'b0};
        vecs[6]  = '{8'd7,  4, 8'd50, 1'b0};
        vecs[7]  = '{8'd8,  3, 8'd10, 1'b0};
        vecs[8]  = '{8'd9,  5, 8'd10, 1'b0};
        vecs[9]  = '{8'd10, 6, 8'd10, 1'b0};
        vecs[10] = '{8'd11, 7, 8'd42, 1'b0};
        vecs[11] = '{8'd11, 7, 8'd42, 1'b1};

        rst = 1'b1;
        #1;
        check("reset pc", {8'd0, pc_out}, 16'd0);
        check("reset halt", {15'd0, halt}, 16'd0);
        check("reset r3", {8'd0, r3}, 16'd0);
        check("reset instr", dut.instruction, 16'h000F);
        @(negedge clk);
        rst = 1'b0;

        // ROM program, one instruction per step
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("prog pc step%0d", i), {8'd0, pc_out}, {8'd0, vecs[i].exp_pc});
            check($sformatf("prog r%0d step%0d", vecs[i].ridx, i),
                  {8'd0, get_reg(vecs[i].ridx)}, {8'd0, vecs[i].exp_val});
            check($sformatf("prog halt step%0d", i), {15'd0, halt}, {15'd0, vecs[i].exp_halt});
        end
        check("sub flags", {13'd0, dut.flags}, 16'd0);
        check_final("final");

        for (int i = 0; i < 10; i++) step();
        check_final("hold");

        // Mid-run async reset
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("mid pc before rst", {8'd0, pc_out}, 16'd5);
        rst = 1'b1;
        #1;
        check("mid rst pc", {8'd0, pc_out}, 16'd0);
        check("mid rst halt", {15'd0, halt}, 16'd0);
        for (int i = 0; i < 8; i++)
            check($sformatf("mid rst r%0d", i), {8'd0, get_reg(i)}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 15 && !halt; i++) step();
        check_final("rerun");

        // JZ taken
        ovr_en = 1'b1;
        ovr = '{16'h0200, 16'hD205, 16'h0401, 16'h0401, 16'h0401, 16'hF000, 16'hF000, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("jz halt", {15'd0, halt}, 16'd1);
        check("jz pc", {8'd0, pc_out}, 16'd5);
        check("jz r2", {8'd0, r2}, 16'd0);

        // JNZ taken
        ovr = '{16'h0203, 16'hE205, 16'h0401, 16'h0401, 16'h0401, 16'hF000, 16'hF000, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("jnz halt", {15'd0, halt}, 16'd1);
        check("jnz pc", {8'd0, pc_out}, 16'd5);
        check("jnz r1", {8'd0, r1}, 16'd3);
        check("jnz r2", {8'd0, r2}, 16'd0);

        // ALU: build 200 and 100, ADD with carry, CMP, NOT
        ovr = '{16'h0032, 16'h1000, 16'h1000, 16'h0232, 16'h1240, 16'h1040, 16'hB000, 16'hF0C0,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        do_reset();
        for (int i = 0; i < 6; i++) step();
        check("alu r0", {8'd0, r0}, 16'd200);
        check("add r1", {8'd0, r1}, 16'd44);
        check("add flags zn c", {13'd0, dut.flags}, 16'b001);
        step();
        check("cmp flags", {13'd0, dut.flags}, 16'b100);
        check("cmp r0", {8'd0, r0}, 16'd200);
        check("cmp r1", {8'd0, r1}, 16'd44);
        step();
        check("not r3", {8'd0, r3}, 16'd55);
        step();
        check("alu halt", {15'd0, halt}, 16'd1);

        // Shifter
`ifdef CPU_SHIFT_EN
        sh1 = 8'd12;
        sh2 = 8'd0;
`else
        sh1 = 8'd2;
        sh2 = 8'd2;
`endif
        ovr = '{16'h0003, 16'h0202, 16'h8040, 16'h9040, 16'hF000, 16'hF000, 16'hF000, 16'hF000,
                16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000};
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check("shl r1", {8'd0, r1}, {8'd0, sh1});
        step();
        check("shr r1", {8'd0, r1}, {8'd0, sh2});
        check("shift pc", {8'd0, pc_out}, 16'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
